// File: rtl/lsu_mem_responder.sv
// rtl/lsu_mem_responder.sv - word-addressed 64-bit data memory with fixed-latency pipelined reads
module lsu_mem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic [63:0] mem_raddr,
    output logic        mem_rvalid,
    output logic [63:0] mem_rdata,
    input  logic        mem_wen,
    input  logic [63:0] mem_waddr,
    input  logic [63:0] mem_wdata,
    output logic        err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    // Storage is deliberately never reset so contents survive a reset pulse.
    logic [63:0] mem_q [DEPTH];

    logic              rd_in_range;
    logic              wr_in_range;
    logic [AW-1:0]     ridx;
    logic [AW-1:0]     widx;
    logic              write_en;
    logic [63:0]       sample;

    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] vld_d;
    logic [63:0]         dat_q [READ_LAT];
    logic [63:0]         dat_d [READ_LAT];

    logic        err_q;
    logic        err_d;
    logic [31:0] rd_count_q;
    logic [31:0] rd_count_d;
    logic [31:0] wr_count_q;
    logic [31:0] wr_count_d;

    // Full-width compare: an address above DEPTH never aliases onto a low word.
    always_comb begin
        rd_in_range = (mem_raddr < DEPTH_W);
        wr_in_range = (mem_waddr < DEPTH_W);
        ridx        = mem_raddr[AW-1:0];
        widx        = mem_waddr[AW-1:0];
        write_en    = rst & mem_wen & wr_in_range;
    end

    // Read sample with write-first bypass; out-of-range reads return zero.
    always_comb begin
        sample = '0;
        if (rd_in_range) begin
            if (mem_wen && wr_in_range && (mem_waddr == mem_raddr)) begin
                sample = mem_wdata;
            end else begin
                sample = mem_q[ridx];
            end
        end
    end

    // Memory write port; requests during reset are ignored.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[widx] <= mem_wdata;
        end
    end

    // Next state of the read pipeline, error flag and counters.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = mem_ren;
        dat_d[0] = mem_ren ? sample : 64'h0;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        err_d      = (mem_ren && !rd_in_range) || (mem_wen && !wr_in_range);
        rd_count_d = rd_count_q + {31'h0, mem_ren};
        wr_count_d = wr_count_q + {31'h0, mem_wen};
    end

    // Registered state; reset flushes every in-flight read so none ever emerges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q      <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= '0;
            end
            err_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            vld_q      <= vld_d;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Data travels as zero alongside an invalid slot, so rdata is 0 whenever rvalid is 0.
    assign mem_rvalid = vld_q[READ_LAT-1];
    assign mem_rdata  = dat_q[READ_LAT-1];
    assign err        = err_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb/tb_lsu_mem_responder.sv - scoreboard bench for lsu_mem_responder
module tb_lsu_mem_responder;

    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic        clk;
    logic        rst;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    lsu_mem_responder #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
    } rd_exp_t;

    rd_exp_t     sbq[$];
    logic [63:0] shadow [bit [63:0]];
    int          cyc;
    int          n_checks;
    int          n_fail;
    bit          mon_en;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    logic        exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus cycle: drive inputs, update the reference model, advance past the edge.
    task automatic drive(input logic r, input logic ren, input logic [63:0] raddr,
                         input logic wen, input logic [63:0] waddr, input logic [63:0] wdata);
        rd_exp_t e;
        logic    nerr;
        rst       = r;
        mem_ren   = ren;
        mem_raddr = raddr;
        mem_wen   = wen;
        mem_waddr = waddr;
        mem_wdata = wdata;
        nerr      = 1'b0;
        if (r) begin
            if (wen) begin
                if (waddr < 64'(DEPTH)) shadow[waddr] = wdata;
                else nerr = 1'b1;
            end
            if (ren) begin
                e.due = cyc + RL;
                if (raddr < 64'(DEPTH)) e.data = shadow[raddr];
                else begin
                    e.data = 64'h0;
                    nerr   = 1'b1;
                end
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (!r) begin
            exp_rd  = '0;
            exp_wr  = '0;
            exp_err = 1'b0;
            sbq.delete();
        end else begin
            exp_rd  = exp_rd + {31'h0, ren};
            exp_wr  = exp_wr + {31'h0, wen};
            exp_err = nerr;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        drive(1'b1, 1'b0, 64'h0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [63:0] a);
        drive(1'b1, 1'b1, a, 1'b0, 64'h0, 64'h0);
    endtask

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                check("rvalid", {63'h0, mem_rvalid}, 64'h1);
                check("rdata", mem_rdata, sbq[0].data);
                void'(sbq.pop_front());
            end else begin
                check("rvalid_idle", {63'h0, mem_rvalid}, 64'h0);
                check("rdata_idle", mem_rdata, 64'h0);
            end
            check("err", {63'h0, err}, {63'h0, exp_err});
            check("rd_count", {32'h0, rd_count}, {32'h0, exp_rd});
            check("wr_count", {32'h0, wr_count}, {32'h0, exp_wr});
        end
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        exp_rd   = '0;
        exp_wr   = '0;
        exp_err  = 1'b0;
        rst = 1'b0; mem_ren = 1'b0; mem_raddr = '0; mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0;

        // Reset held with requests active: nothing written, counted or returned.
        drive(1'b0, 1'b1, 64'h3, 1'b1, 64'h3, 64'h5555);
        mon_en = 1'b1;
        drive(1'b0, 1'b1, 64'h3, 1'b1, 64'h3, 64'h5555);
        drive(1'b0, 1'b1, 64'h3, 1'b1, 64'h3, 64'h5555);
        idle(10);

        // Write then read.
        wr(64'd5, 64'hDEAD_BEEF_0000_0005);
        rd(64'd5);
        idle(3);

        // Write-first and ordering.
        wr(64'd7, 64'h1111);
        idle(1);
        rd(64'd7);
        drive(1'b1, 1'b1, 64'd7, 1'b1, 64'd7, 64'h2222);
        idle(3);

        // Pipelined burst.
        for (int i = 0; i < 8; i++) wr(64'(i), 64'(i + 100));
        for (int i = 0; i < 8; i++) rd(64'(i));
        idle(3);

        // Out of range accesses and the top boundary.
        rd(64'd1024);
        idle(3);
        wr(64'h1_0000_0000, 64'hFF);
        idle(1);
        rd(64'd0);
        drive(1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'd2048, 64'h77);
        wr(64'd1023, 64'hABC);
        rd(64'd1023);
        rd(64'h0000_0001_0000_0000);
        idle(3);

        // Reset mid-flight: the pending read is flushed, memory survives.
        rd(64'd0);
        rd(64'd1);
        rd(64'd2);
        drive(1'b0, 1'b1, 64'd3, 1'b1, 64'd0, 64'hBAD);
        idle(10);
        rd(64'd0);
        rd(64'd1);
        rd(64'd2);
        idle(3);

        // Random mixed traffic over a small written window plus occasional out-of-range.
        for (int i = 8; i < 16; i++) wr(64'(i), 64'(i * 3 + 1));
        for (int i = 0; i < 300; i++) begin
            logic        ren_r;
            logic        wen_r;
            logic [63:0] ra;
            logic [63:0] wa;
            ren_r = 1'($urandom_range(0, 1));
            wen_r = 1'($urandom_range(0, 1));
            ra    = ($urandom_range(0, 19) == 0) ? 64'(DEPTH + $urandom_range(0, 5)) : 64'($urandom_range(0, 15));
            wa    = ($urandom_range(0, 19) == 0) ? 64'(DEPTH + $urandom_range(0, 5)) : 64'($urandom_range(0, 15));
            drive(1'b1, ren_r, ra, wen_r, wa, {$urandom, $urandom});
        end
        idle(RL + 2);

        check("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
